// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 serial transmitter, byte FIFO in front of a bit-timing FSM.
// Latency: a byte written into an empty FIFO with the line idle starts its start bit on the next edge.
// Backpressure: none on the write side; writes arriving while the FIFO is full are dropped and set sticky overflow.
module uart_tx #(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          tx,
  output logic                          busy,
  output logic                          full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int LW           = AW + 1;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0]    DEPTH_LVL  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] baud_cnt;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic             wr_acc;
  logic             pop;
  logic             fifo_nonempty;
  logic             baud_done;
  logic [7:0]       head_dat;

  // Acceptance and pop are both judged on the registered level, so a write
  // into a full FIFO is dropped even if a pop happens on the same edge.
  assign fifo_nonempty = (level != '0);
  assign baud_done     = (baud_cnt == '0);
  assign wr_acc        = wr_en && (level < DEPTH_LVL);
  assign pop           = fifo_nonempty &&
                         ((state == S_IDLE) || ((state == S_STOP) && baud_done));
  assign head_dat      = mem[rd_ptr];
  assign full          = (level == DEPTH_LVL);
  assign busy          = (state != S_IDLE) || fifo_nonempty;

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level + LW'(wr_acc) - LW'(pop);
      if (wr_en && !wr_acc) begin
        overflow <= 1'b1;
      end
    end
  end

  // Frame sequencer: start bit, eight data bits LSB first, stop bit; a pending
  // byte at the end of the stop bit chains straight into the next start bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift    <= head_dat;
            baud_cnt <= CNT_RELOAD;
            tx       <= 1'b0;
            state    <= S_START;
          end
        end

        S_START: begin
          if (baud_done) begin
            baud_cnt <= CNT_RELOAD;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= CNT_RELOAD;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              tx      <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        S_STOP: begin
          if (baud_done) begin
            if (pop) begin
              shift    <= head_dat;
              baud_cnt <= CNT_RELOAD;
              tx       <= 1'b0;
              state    <= S_START;
            end else begin
              tx    <= 1'b1;
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed stimulus for uart_tx with a cycle-level occupancy model.
// Latency: expected bytes are queued at acceptance; the line monitor decodes each frame and compares bit by bit.
// Backpressure: the model predicts drops on a full FIFO and the sticky overflow flag.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 4;

  logic       clk;
  logic       resetn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx;
  logic       busy;
  logic       full;
  logic       overflow;
  logic [2:0] level;

  uart_tx #(
    .CLK_FREQ_HZ(16),
    .BAUD_RATE  (4),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .tx      (tx),
    .busy    (busy),
    .full    (full),
    .overflow(overflow),
    .level   (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO occupancy count, time left in the current frame,
  // and the queue of bytes still to appear on the line.
  logic [7:0] exp_q[$];
  int         m_level     = 0;
  int         frame_left  = 0;
  bit         m_ovf       = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        exp_q.delete();
        m_level    = 0;
        frame_left = 0;
        m_ovf      = 1'b0;
      end else begin
        bit do_pop;
        bit acc;
        do_pop = (m_level > 0) && (frame_left <= 1);
        acc    = wr_en && (m_level < DEPTH);
        if (wr_en && !acc) m_ovf = 1'b1;
        if (acc) exp_q.push_back(wr_data);
        if (do_pop) frame_left = FRAME;
        else if (frame_left > 0) frame_left--;
        m_level = m_level + int'(acc) - int'(do_pop);
      end
    end
  end

  // Line monitor: decodes frames from tx and checks status outputs each cycle.
  bit         in_frame = 1'b0;
  int         fidx     = 0;
  logic [7:0] cur_byte = '0;
  int         frames   = 0;

  initial begin
    forever begin
      @(negedge clk);
      check("level", int'(level), m_level);
      check("busy", int'(busy), int'((frame_left > 0) || (m_level > 0)));
      check("full", int'(full), int'(m_level == DEPTH));
      check("overflow", int'(overflow), int'(m_ovf));
      if (!resetn) begin
        in_frame = 1'b0;
        check("tx_in_reset", int'(tx), 1);
      end else begin
        if (!in_frame) begin
          if (tx == 1'b0) begin
            check("start_align", frame_left, FRAME);
            if (exp_q.size() == 0) begin
              check("unexpected_frame", 1, 0);
              cur_byte = '0;
            end else begin
              cur_byte = exp_q.pop_front();
            end
            in_frame = 1'b1;
            fidx     = 0;
          end else begin
            check("idle_align", frame_left, 0);
          end
        end
        if (in_frame) begin
          int   slot;
          logic exp_bit;
          slot = fidx / CPB;
          if (slot == 0)      exp_bit = 1'b0;
          else if (slot == 9) exp_bit = 1'b1;
          else                exp_bit = cur_byte[slot-1];
          check($sformatf("tx_bit byte=%02h slot=%0d", cur_byte, slot), int'(tx), int'(exp_bit));
          fidx++;
          if (fidx == FRAME) begin
            in_frame = 1'b0;
            frames++;
          end
        end
      end
    end
  end

  task automatic drive(input bit en, input logic [7:0] d);
    @(negedge clk);
    wr_en   = en;
    wr_data = d;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (!(frame_left == 0 && m_level == 0 && !in_frame) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) check("drain_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_frame_left(input int target, input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (frame_left != target && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) check($sformatf("wait_frame_left_%0d_timeout", target), 1, 0);
  endtask

  initial begin
    int pct;
    resetn  = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", int'(tx), 1);
    check("reset_level", int'(level), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_full", int'(full), 0);
    check("reset_overflow", int'(overflow), 0);
    resetn = 1'b1;

    // Single byte.
    drive(1'b1, 8'hA5);
    drive(1'b0, 8'h00);
    wait_idle(200);

    // Five back-to-back writes with the line idle: all five fit.
    for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i));
    drive(1'b0, 8'h00);
    check("no_overflow_after_five", int'(overflow), 0);
    wait_idle(400);

    // Fill while a frame runs: later writes are dropped.
    drive(1'b1, 8'h10);
    drive(1'b0, 8'h00);
    repeat (2) drive(1'b0, 8'h00);
    for (int i = 1; i <= 6; i++) drive(1'b1, 8'(8'h10 + i));
    drive(1'b0, 8'h00);
    check("overflow_set", int'(overflow), 1);
    wait_idle(400);
    check("overflow_sticky", int'(overflow), 1);

    // Write on the edge that ends a stop bit with one byte already queued.
    drive(1'b1, 8'h5A);
    drive(1'b0, 8'h00);
    repeat (3) drive(1'b0, 8'h00);
    drive(1'b1, 8'hC3);
    drive(1'b0, 8'h00);
    wait_frame_left(1, 200);
    wr_en   = 1'b1;
    wr_data = 8'h96;
    @(negedge clk);
    wr_en = 1'b0;
    check("same_edge_level", int'(level), 1);
    wait_idle(400);

    // Reset during data bit 3 of 0x00, then a fresh byte.
    drive(1'b1, 8'h00);
    drive(1'b0, 8'h00);
    wait_frame_left(FRAME - 18, 200);
    #2 resetn = 1'b0;
    #1;
    check("abort_tx", int'(tx), 1);
    check("abort_level", int'(level), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_overflow", int'(overflow), 0);
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b1, 8'h3C);
    drive(1'b0, 8'h00);
    wait_idle(200);

    // Random traffic with varying write density.
    for (int i = 0; i < 800; i++) begin
      case (i / 200)
        0:       pct = 10;
        1:       pct = 40;
        2:       pct = 90;
        default: pct = 25;
      endcase
      drive($urandom_range(0, 99) < pct, 8'($urandom));
    end
    drive(1'b0, 8'h00);
    wait_idle(600);

    check("all_bytes_sent", exp_q.size(), 0);
    check("frames_seen_nonzero", int'(frames > 20), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
